vec_mem_seq: RTL and testbench

//  Strided vector load/store sequencer driving port A (w/addr/din/dout) of the

---
 rtl/vec_mem_seq_if.sv | 32 +++
 rtl/vec_mem_seq.sv | 90 +++++++++
 tb/tb_vec_mem_seq.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_mem_seq_if.sv
// Command and RAM port-A bundle for the strided vector load/store sequencer.
// slave = sequencer; master = command issuer together with the RAM that returns mem_dout.
interface vec_mem_seq_if #(
   parameter int ADDR_WIDTH = 19,
   parameter int DATA_WIDTH = 32,
   parameter int VLEN       = 8,
   parameter int LEN_W      = 4
);
   logic                         start;
   logic                         is_store;
   logic [ADDR_WIDTH-1:0]        base_addr;
   logic [ADDR_WIDTH-1:0]        stride;
   logic [LEN_W-1:0]             len;
   logic [VLEN*DATA_WIDTH-1:0]   st_data;
   logic                         busy;
   logic                         done;
   logic [VLEN*DATA_WIDTH-1:0]   ld_data;
   logic                         mem_w;
   logic [ADDR_WIDTH-1:0]        mem_addr;
   logic [DATA_WIDTH-1:0]        mem_din;
   logic [DATA_WIDTH-1:0]        mem_dout;

   modport master (
      output start, is_store, base_addr, stride, len, st_data, mem_dout,
      input  busy, done, ld_data, mem_w, mem_addr, mem_din
   );

   modport slave (
      input  start, is_store, base_addr, stride, len, st_data, mem_dout,
      output busy, done, ld_data, mem_w, mem_addr, mem_din
   );
endinterface

// File: rtl/vec_mem_seq.sv
// Strided vector load/store sequencer: one element access per clock on RAM port A,
// loads assembled into a VLEN-wide result, stores taken from a VLEN-wide operand.
module vec_mem_seq #(
   parameter int ADDR_WIDTH = 19,
   parameter int DATA_WIDTH = 32,
   parameter int VLEN       = 8,
   parameter int LEN_W      = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   vec_mem_seq_if.slave     bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]                 r_state;
   logic                       r_is_store;
   logic [ADDR_WIDTH-1:0]      r_stride;
   logic [LEN_W-1:0]           r_len;
   logic [LEN_W-1:0]           r_idx;
   logic [ADDR_WIDTH-1:0]      r_mem_addr;
   logic [VLEN*DATA_WIDTH-1:0] r_st_data;
   logic [VLEN*DATA_WIDTH-1:0] r_ld_data;

   logic [LEN_W-1:0]           w_len_eff;
   logic [LEN_W-1:0]           w_last_idx;

   always_comb begin
      w_len_eff = (bus.len > LEN_W'(VLEN)) ? LEN_W'(VLEN) : bus.len;
   end

   assign w_last_idx = r_len - LEN_W'(1);

   // NOTE: every flop, including the wide operand/result vectors, is cleared by the
   // async reset so an interrupted command leaves no stale data visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_is_store <= 1'b0;
         r_stride   <= '0;
         r_len      <= '0;
         r_idx      <= '0;
         r_mem_addr <= '0;
         r_st_data  <= '0;
         r_ld_data  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register reading pre-edge values.
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_is_store <= bus.is_store;
                  r_stride   <= bus.stride;
                  r_len      <= w_len_eff;
                  r_idx      <= '0;
                  r_mem_addr <= bus.base_addr;
                  // Zero-length commands leave mem_din holding its previous value.
                  if (w_len_eff != '0) r_st_data <= bus.st_data;
                  if (!bus.is_store)   r_ld_data <= '0;
                  r_state <= (w_len_eff == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (!r_is_store) begin
                  for (int i = 0; i < VLEN; i++) begin
                     if (r_idx == LEN_W'(i)) r_ld_data[i*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_dout;
                  end
               end
               if (r_idx == w_last_idx) begin
                  r_state <= S_DONE;
               end else begin
                  r_idx      <= r_idx + LEN_W'(1);
                  r_mem_addr <= r_mem_addr + r_stride;
                  // The store operand shifts down so the current element always sits at bit 0.
                  r_st_data  <= r_st_data >> DATA_WIDTH;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy     = (r_state != S_IDLE);
   assign bus.done     = (r_state == S_DONE);
   assign bus.mem_w    = (r_state == S_RUN) && r_is_store;
   assign bus.mem_addr = r_mem_addr;
   assign bus.mem_din  = r_st_data[DATA_WIDTH-1:0];
   assign bus.ld_data  = r_ld_data;
endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed bench for vec_mem_seq with a negedge-clocked RAM model on port A.
module tb_vec_mem_seq;
   localparam int AW = 19;
   localparam int DW = 32;
   localparam int VL = 8;
   localparam int LW = 4;
   localparam int VW = VL*DW;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   vec_mem_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .VLEN(VL), .LEN_W(LW)) bus ();

   vec_mem_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .VLEN(VL), .LEN_W(LW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // RAM model: writes and registers the read address on negedge.
   logic [DW-1:0] ram [0:(1<<AW)-1];
   logic [AW-1:0] rd_addr;
   assign bus.mem_dout = ram[rd_addr];
   always @(negedge clk) begin
      if (bus.mem_w) ram[bus.mem_addr] <= bus.mem_din;
      rd_addr <= bus.mem_addr;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_cmd(input logic st, input logic [AW-1:0] base, input logic [AW-1:0] strd,
                            input logic [LW-1:0] l, input logic [VW-1:0] sd);
      bus.is_store  = st;
      bus.base_addr = base;
      bus.stride    = strd;
      bus.len       = l;
      bus.st_data   = sd;
      bus.start     = 1'b1;
      step();
      bus.start     = 1'b0;
   endtask

   task automatic wait_done(output bit seen);
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) step();
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
      n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", bus.done); end
      n_tests++; if (bus.mem_w !== 1'b0) begin n_fail++; $display("FAIL reset_mem_w: got %b exp 0", bus.mem_w); end
      n_tests++; if (bus.mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h exp 0", bus.mem_addr); end
      n_tests++; if (bus.mem_din !== '0) begin n_fail++; $display("FAIL reset_mem_din: got %h exp 0", bus.mem_din); end
      n_tests++; if (bus.ld_data !== '0) begin n_fail++; $display("FAIL reset_ld_data: got %h exp 0", bus.ld_data); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_load_basic();
      logic [VW-1:0] exp_ld;
      exp_ld = '0;
      for (int i = 0; i < 4; i++) begin
         ram[19'h100 + 19'(4*i)] = 32'hA0 + 32'(i);
         exp_ld[i*DW +: DW] = 32'hA0 + 32'(i);
      end
      start_cmd(1'b0, 19'h100, 19'd4, 4'd4, '0);
      for (int i = 0; i < 4; i++) begin
         n_tests++; if (bus.mem_addr !== 19'h100 + 19'(4*i)) begin n_fail++; $display("FAIL load_addr%0d: got %h exp %h", i, bus.mem_addr, 19'h100 + 19'(4*i)); end
         n_tests++; if (bus.mem_w !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL load_ctl%0d: got w=%b done=%b exp 0 0", i, bus.mem_w, bus.done); end
         step();
      end
      n_tests++; if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL load_done: got done=%b busy=%b exp 1 1", bus.done, bus.busy); end
      n_tests++; if (bus.ld_data !== exp_ld) begin n_fail++; $display("FAIL load_data: got %h exp %h", bus.ld_data, exp_ld); end
      step();
      n_tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL load_idle: got busy=%b done=%b exp 0 0", bus.busy, bus.done); end
   endtask

   task automatic test_store_reload();
      logic [VW-1:0] sd;
      int cnt_w, cnt_b, bad;
      bit seen;
      for (int i = 0; i < VL; i++) sd[i*DW +: DW] = 32'h11 * 32'(i);
      cnt_w = 0; cnt_b = 0; bad = 0;
      start_cmd(1'b1, 19'h20, 19'd1, 4'd8, sd);
      for (int c = 0; c < 14; c++) begin
         if (bus.busy === 1'b1) cnt_b++;
         if (bus.mem_w === 1'b1) cnt_w++;
         step();
      end
      n_tests++; if (cnt_w !== 8) begin n_fail++; $display("FAIL store_w_cycles: got %0d exp 8", cnt_w); end
      n_tests++; if (cnt_b !== 9) begin n_fail++; $display("FAIL store_busy_cycles: got %0d exp 9", cnt_b); end
      for (int i = 0; i < VL; i++) if (ram[19'h20 + 19'(i)] !== 32'h11 * 32'(i)) bad++;
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL store_ram: got %0d bad words exp 0", bad); end
      start_cmd(1'b0, 19'h20, 19'd1, 4'd8, sd);
      wait_done(seen);
      n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL reload_done: got no done exp done"); end
      n_tests++; if (bus.ld_data !== sd) begin n_fail++; $display("FAIL reload_data: got %h exp %h", bus.ld_data, sd); end
      step();
   endtask

   task automatic test_len_zero();
      logic [VW-1:0] sd;
      for (int i = 0; i < VL; i++) sd[i*DW +: DW] = 32'h11 * 32'(i);
      start_cmd(1'b1, 19'h55, 19'd3, 4'd0, {VW{1'b1}});
      n_tests++; if (bus.done !== 1'b1 || bus.mem_w !== 1'b0) begin n_fail++; $display("FAIL len0_done: got done=%b w=%b exp 1 0", bus.done, bus.mem_w); end
      n_tests++; if (bus.mem_addr !== 19'h55) begin n_fail++; $display("FAIL len0_addr: got %h exp 55", bus.mem_addr); end
      n_tests++; if (bus.mem_din !== 32'h77) begin n_fail++; $display("FAIL len0_din_hold: got %h exp 77", bus.mem_din); end
      step();
      n_tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mem_w !== 1'b0) begin n_fail++; $display("FAIL len0_idle: got busy=%b done=%b w=%b exp 0 0 0", bus.busy, bus.done, bus.mem_w); end
      n_tests++; if (bus.ld_data !== sd) begin n_fail++; $display("FAIL len0_ld_hold: got %h exp %h", bus.ld_data, sd); end
   endtask

   task automatic test_neg_stride();
      logic [VW-1:0] exp_ld;
      logic [AW-1:0] exp_a [0:2];
      exp_a[0] = 19'h00001; exp_a[1] = 19'h00000; exp_a[2] = 19'h7FFFF;
      ram[19'h00001] = 32'h1111; ram[19'h00000] = 32'h2222; ram[19'h7FFFF] = 32'h3333;
      exp_ld = '0;
      exp_ld[0 +: DW] = 32'h1111; exp_ld[DW +: DW] = 32'h2222; exp_ld[2*DW +: DW] = 32'h3333;
      start_cmd(1'b0, 19'h1, 19'h7FFFF, 4'd3, '0);
      for (int i = 0; i < 3; i++) begin
         n_tests++; if (bus.mem_addr !== exp_a[i]) begin n_fail++; $display("FAIL neg_addr%0d: got %h exp %h", i, bus.mem_addr, exp_a[i]); end
         step();
      end
      n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL neg_done: got %b exp 1", bus.done); end
      n_tests++; if (bus.ld_data !== exp_ld) begin n_fail++; $display("FAIL neg_data: got %h exp %h", bus.ld_data, exp_ld); end
      step();
   endtask

   task automatic test_zero_stride();
      logic [VW-1:0] sd, exp_ld;
      bit seen;
      sd = '0;
      for (int i = 0; i < 3; i++) sd[i*DW +: DW] = 32'(i + 1);
      ram[19'h500] = '0;
      start_cmd(1'b1, 19'h500, 19'd0, 4'd3, sd);
      wait_done(seen);
      step();
      n_tests++; if (ram[19'h500] !== 32'd3) begin n_fail++; $display("FAIL zs_store: got %h exp 3", ram[19'h500]); end
      exp_ld = '0;
      exp_ld[0 +: DW] = 32'd3; exp_ld[DW +: DW] = 32'd3;
      start_cmd(1'b0, 19'h500, 19'd0, 4'd2, '0);
      wait_done(seen);
      n_tests++; if (seen !== 1'b1 || bus.ld_data !== exp_ld) begin n_fail++; $display("FAIL zs_load: got %h exp %h", bus.ld_data, exp_ld); end
      step();
   endtask

   task automatic test_reset_mid();
      logic [VW-1:0] sd;
      int bad, dn;
      for (int i = 0; i < VL; i++) begin
         ram[19'h200 + 19'(i)] = 32'hDEAD0000 + 32'(i);
         sd[i*DW +: DW] = 32'hC0 + 32'(i);
      end
      start_cmd(1'b1, 19'h200, 19'd1, 4'd8, sd);
      repeat (3) step();
      #1;
      rst_n = 1'b0;
      #1;
      n_tests++; if (bus.mem_w !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_ctl: got w=%b busy=%b exp 0 0", bus.mem_w, bus.busy); end
      dn = 0;
      for (int c = 0; c < 4; c++) begin
         if (bus.done !== 1'b0) dn++;
         step();
      end
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (bus.done !== 1'b0 || bus.mem_w !== 1'b0) dn++;
         step();
      end
      n_tests++; if (dn !== 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d bad cycles exp 0", dn); end
      n_tests++; if (bus.mem_addr !== '0 || bus.ld_data !== '0) begin n_fail++; $display("FAIL rmid_regs: got addr=%h ld=%h exp 0 0", bus.mem_addr, bus.ld_data); end
      bad = 0;
      for (int i = 0; i < 3; i++) if (ram[19'h200 + 19'(i)] !== 32'hC0 + 32'(i)) bad++;
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rmid_written: got %0d bad words exp 0", bad); end
      bad = 0;
      for (int i = 4; i < VL; i++) if (ram[19'h200 + 19'(i)] !== 32'hDEAD0000 + 32'(i)) bad++;
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rmid_untouched: got %0d bad words exp 0", bad); end
   endtask

   task automatic test_start_held();
      logic          bz [0:11];
      logic          dn [0:11];
      logic [AW-1:0] ad [0:11];
      logic [VW-1:0] exp_ld;
      int n_run, done_at;
      ram[19'h400] = 32'h4444;
      exp_ld = '0;
      exp_ld[0 +: DW] = 32'h4444;
      bus.is_store = 1'b0; bus.base_addr = 19'h300; bus.stride = 19'd1; bus.len = 4'd12; bus.st_data = '0;
      bus.start = 1'b1;
      step();
      bus.base_addr = 19'h400; bus.len = 4'd1;
      n_run = 0; done_at = -1;
      for (int c = 0; c < 12; c++) begin
         bz[c] = bus.busy; dn[c] = bus.done; ad[c] = bus.mem_addr;
         if (c < 9 && bus.busy === 1'b1 && bus.done === 1'b0) n_run++;
         if (bus.done === 1'b1 && done_at < 0) done_at = c;
         step();
      end
      bus.start = 1'b0;
      n_tests++; if (n_run !== 8) begin n_fail++; $display("FAIL held_accesses: got %0d exp 8", n_run); end
      n_tests++; if (done_at !== 8) begin n_fail++; $display("FAIL held_done_at: got %0d exp 8", done_at); end
      n_tests++; if (bz[9] !== 1'b0) begin n_fail++; $display("FAIL held_idle_gap: got busy=%b exp 0", bz[9]); end
      n_tests++; if (bz[10] !== 1'b1 || ad[10] !== 19'h400) begin n_fail++; $display("FAIL held_accept: got busy=%b addr=%h exp 1 400", bz[10], ad[10]); end
      n_tests++; if (dn[11] !== 1'b1) begin n_fail++; $display("FAIL held_done2: got %b exp 1", dn[11]); end
      step();
      n_tests++; if (bus.ld_data !== exp_ld || bus.busy !== 1'b0) begin n_fail++; $display("FAIL held_ld: got %h busy=%b exp %h 0", bus.ld_data, bus.busy, exp_ld); end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      rd_addr = '0;
      bus.start = 1'b0; bus.is_store = 1'b0; bus.base_addr = '0; bus.stride = '0;
      bus.len = '0; bus.st_data = '0;
      for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
      test_reset();
      test_load_basic();
      test_store_reload();
      test_len_zero();
      test_neg_stride();
      test_zero_stride();
      test_reset_mid();
      test_start_held();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
